// File: rtl/digit_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package digit_serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of nibble steps needed for an operand of the given width.
  function automatic int unsigned nibble_count(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder4.sv
// 4-bit carry-lookahead adder used as the per-cycle nibble datapath.
module carry_lookahead_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: {cout,s} = a + b + cin, one nibble per cycle, LSB first.
// Optional overflow output enabled by defining DIGIT_SERIAL_ADDER_OVF_EN.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB   = nibble_count(WIDTH);
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   s_q;
  logic               carry_q;
  logic               cout_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_c;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] nib_sum;
  logic               nib_cout;

  assign last_c = (cnt_q == CNT_W'(NIB - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_c)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand nibble select for the current step
  always_comb begin
    a_nib = a_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W];
    b_nib = b_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W];
  end

  carry_lookahead_adder4 u_cla (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Operand capture and nibble-serial accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          s_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W] <= nib_sum;
          carry_q <= nib_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_c) cout_q <= nib_cout;
        end
        default: ;
      endcase
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow judged on the MSB nibble as it is produced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last_c) begin
      ovf_q <= (a_nib[NIBBLE_W-1] == b_nib[NIBBLE_W-1]) &&
               (nib_sum[NIBBLE_W-1] != a_nib[NIBBLE_W-1]);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder; OVF checks follow DIGIT_SERIAL_ADDER_OVF_EN.
module tb_digit_serial_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  bit   or_force = 1'b1;
  bit   or_val = 1'b1;
  bit   prev_ov = 1'b0;
  bit   hs_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name);
    total_cnt++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Reference model: plain wide addition and sign-rule overflow
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    logic [WIDTH:0] t;
    exp_t r;
    t      = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
    r.s    = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    r.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    r.acc  = 0;
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = or_force ? or_val : ($urandom_range(0, 3) != 0);
  end

  // Monitor: push on accept, compare whenever a result is presented
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ov = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) check("in_ready_after_handshake", 64'(in_ready), 64'd1);
      if (in_valid && in_ready) begin
        e     = model(a, b, cin);
        e.acc = cyc + 1;
        sb.push_back(e);
      end
      if (out_valid) begin
        check("in_ready_low_in_done", 64'(in_ready), 64'd0);
        check("result_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb[0];
          if (!prev_ov) check("latency", 64'(cyc), 64'(e.acc + int'(NIB)));
          check("sum", 64'(s), 64'(e.s));
          check("cout", 64'(cout), 64'(e.cout));
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
          check("ovf", 64'(ovf), 64'(e.ovf));
`endif
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_ov = out_valid && !out_ready;
      hs_prev = out_valid && out_ready;
    end
  end

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                      output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    a = x; b = y; cin = c; in_valid = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        acc = cyc + 1;
      end
    end
    if (!got) fail_bound("accept_wait");
    @(posedge clk); #1;
    in_valid = 1'b0;
    a   = WIDTH'($urandom);
    b   = WIDTH'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic drain(input int limit);
    bit done;
    done = 1'b0;
    for (int k = 0; k < limit && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready) done = 1'b1;
    end
    if (!done) fail_bound("drain");
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_s"},         64'(s),         64'd0);
    check({tag, "_cout"},      64'(cout),      64'd0);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"},       64'(ovf),       64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  acc;
    int  hs;
    int  acc2;
    bit  got;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Directed sums, consumer always ready
    send(16'h1234, 16'h4321, 1'b0, acc);
    send(16'hFFFF, 16'h0001, 1'b0, acc);
    send(16'hFFFF, 16'h0000, 1'b1, acc);
    send(16'h0000, 16'h0000, 1'b0, acc);
    send(16'h7FFF, 16'h0001, 1'b0, acc);
    send(16'h8000, 16'hFFFF, 1'b0, acc);
    send(16'h0001, 16'h0001, 1'b0, acc);
    drain(100);

    // Back-pressure in DONE with a new pair already offered
    or_val = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, acc);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) fail_bound("out_valid_wait");
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("stall_s", 64'(s), 64'h3333);
      check("stall_cout", 64'(cout), 64'd0);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    or_val = 1'b1;
    hs = -1;
    for (int k = 0; k < 20 && hs < 0; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) hs = cyc + 1;
    end
    if (hs < 0) fail_bound("handshake_wait");
    acc2 = -1;
    for (int k = 0; k < 20 && acc2 < 0; k++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc2 = cyc + 1;
    end
    if (acc2 < 0) fail_bound("held_accept_wait");
    else check("held_accept_cycle", 64'(acc2), 64'(hs + 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain(100);

    // Reset in the second RUN cycle discards the result in flight
    send(16'hABCD, 16'h1111, 1'b0, acc);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_values("mid_run_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (NIB + 3) begin
      @(negedge clk);
      check("no_valid_after_reset", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(16'h00FF, 16'h0001, 1'b0, acc);
    drain(100);

    // Randomised traffic with random back-pressure and gaps
    or_force = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), acc);
    end
    drain(400);
    or_force = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, 16, operand width in bits; legal values are multiples of 4, from 4 to 64.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port IN_VALID, input, 1, operand pair valid.
REQ-005 The block SHALL have port IN_READY, output, 1, block accepts an operand pair.
REQ-006 The block SHALL have port A, input, WIDTH, augend, sampled on accept.
REQ-007 The block SHALL have port B, input, WIDTH, addend, sampled on accept.
REQ-008 The block SHALL have port CIN, input, 1, carry-in, sampled on accept.
REQ-009 The block SHALL have port OUT_VALID, output, 1, result valid.
REQ-010 The block SHALL have port OUT_READY, input, 1, consumer accepts the result.
REQ-011 The block SHALL have port S, output, WIDTH, sum.
REQ-012 The block SHALL have port COUT, output, 1, carry-out of the MSB.

Function
REQ-013 The block SHALL compute {COUT,S} = A + B + CIN, modulo 2^(WIDTH+1), processing one 4-bit nibble per cycle, LSB nibble first.
REQ-014 The FSM SHALL have states IDLE, RUN, DONE; IN_READY=1 only in IDLE; OUT_VALID=1 only in DONE.
REQ-015 On an IDLE cycle with IN_VALID=1, the block SHALL latch A, B, and CIN into the carry register, clear the nibble counter, and go to RUN.
REQ-016 In RUN, each cycle, the block SHALL add nibble[cnt] of the latched A and B with the carry register, write the 4-bit sum into nibble[cnt] of the result register, load the carry register from the nibble carry-out, and increment cnt.
REQ-017 When cnt reaches WIDTH/4-1 in RUN, the block SHALL go to DONE on that edge, so OUT_VALID rises exactly WIDTH/4 cycles after the accept edge (4 for WIDTH=16).
REQ-018 In DONE, S and COUT SHALL hold stable until a cycle with OUT_READY=1; the block SHALL then return to IDLE, and IN_READY SHALL be 1 on the following cycle.
REQ-019 While not in IDLE, the block SHALL ignore IN_VALID, A, B and CIN; a held IN_VALID SHALL be accepted on the next IDLE cycle.
REQ-020 When WIDTH=4, RUN SHALL last exactly one cycle.
REQ-021 S and COUT SHALL be driven from registers only, with no combinational path from inputs to outputs.

Reset
REQ-022 RST=1 SHALL immediately force IDLE, IN_READY=1, OUT_VALID=0, S=0, COUT=0, cnt=0 and carry register=0, including in the middle of RUN or DONE.
REQ-023 A result in flight when reset asserts SHALL be discarded, and no OUT_VALID pulse SHALL follow reset release.

Configuration
REQ-024 With macro DIGIT_SERIAL_ADDER_OVF_EN defined, the block SHALL add output OVF (1 bit, reset 0), valid with OUT_VALID, equal to the two's-complement overflow of the MSB nibble: (A[msb]==B[msb]) && (S[msb]!=A[msb]).
REQ-025 Without DIGIT_SERIAL_ADDER_OVF_EN, the OVF port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package digit_serial_adder_pkg SHALL hold the state typedef (IDLE/RUN/DONE), the constant NIBBLE_W=4, and a function giving the nibble count WIDTH/NIBBLE_W.
REQ-027 The nibble datapath SHALL be exactly one instance of carry_lookahead_adder4, fed by the muxed operand nibbles and the carry register; its Cout SHALL feed the carry register.

Verification
REQ-028 Test: A=0x1234, B=0x4321, CIN=0 -> S=0x5555, COUT=0, OUT_VALID exactly 4 cycles after accept.
REQ-029 Test: A=0xFFFF, B=0x0001, CIN=0 -> S=0x0000, COUT=1 (carry ripples through all four nibbles).
REQ-030 Test: A=0xFFFF, B=0x0000, CIN=1 -> S=0x0000, COUT=1; and A=0, B=0, CIN=0 -> S=0, COUT=0.
REQ-031 Test: OUT_READY=0 for 10 cycles in DONE, with IN_VALID=1 and new operands applied -> S, COUT stable, IN_READY=0; after OUT_READY=1, the next pair is accepted one cycle later.
REQ-032 Test: RST asserted on the 2nd RUN cycle -> outputs are reset values at once; after release, a fresh 0x00FF+0x0001 gives S=0x0100, COUT=0.
REQ-033 Test, with DIGIT_SERIAL_ADDER_OVF_EN: 0x7FFF+0x0001 -> OVF=1; 0x8000+0xFFFF -> OVF=1, COUT=1; 0x0001+0x0001 -> OVF=0.
